debounce: RTL and testbench

Push-button debouncer for raw mechanical switch inputs. It synchronises an asynchronous button level into the `clk` domain and rejects bounce and glitches. A new level reaches the output only after it has held steady for a programmable number of clock cycles. It sits between a board-level button pin and the user logic that consumes a clean level, plus one-cycle edge strobes.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/sync_2ff.sv | 29 ++
 rtl/debounce.sv | 67 ++++++
 tb/tb_debounce.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package debounce_pkg;

  localparam int DEBOUNCE_STABLE_CYCLES_DEFAULT = 3;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: synchronise, qualify for STABLE_CYCLES,
// then update the clean level with one-cycle edge strobes.
module debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEFAULT,
  parameter int CNT_W = cnt_width(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_clean,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (btn_sync)
  );

  // Any agreement with the current level restarts qualification.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (btn_sync != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        clean_d = btn_sync;
        rise_d  = btn_sync;
        fall_d  = ~btn_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_clean = clean_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_debounce.sv
// Scoreboard bench for debounce at STABLE_CYCLES 3 and 1,
// checked against a sliding-window model of the sampled input.
module tb_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic c3, r3, f3;
  logic c1, r1, f1;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] expq[$];
  logic       raw[$];
  logic       hist[$];
  logic       m3 = 1'b0;
  logic       m1 = 1'b0;

  always #5 clk = ~clk;

  debounce #(.STABLE_CYCLES(3)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .btn_clean (c3),
    .btn_rise  (r3),
    .btn_fall  (f3)
  );

  debounce #(.STABLE_CYCLES(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .btn_clean (c1),
    .btn_rise  (r1),
    .btn_fall  (f1)
  );

  // True when the last s evaluated sync values all differ from clean.
  function automatic logic window_diff(int s, logic clean);
    if (hist.size() < s) return 1'b0;
    for (int k = 1; k <= s; k++) begin
      if (hist[hist.size() - k] == clean) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: the value compared at edge k is btn sampled
  // at edge k-2; the level flips once a full window disagrees.
  always @(posedge clk) begin
    logic [2:0] e3, e1;
    logic sv;
    if (!rst_n) begin
      raw = {1'b0, 1'b0};
      hist.delete();
      m3 = 1'b0;
      m1 = 1'b0;
      expq.push_back(6'b0);
    end else begin
      raw.push_back(btn);
      sv = raw[raw.size() - 3];
      hist.push_back(sv);
      if (window_diff(3, m3)) begin
        m3 = ~m3;
        e3 = {m3, m3, ~m3};
      end else begin
        e3 = {m3, 2'b00};
      end
      if (window_diff(1, m1)) begin
        m1 = ~m1;
        e1 = {m1, m1, ~m1};
      end else begin
        e1 = {m1, 2'b00};
      end
      expq.push_back({e3, e1});
      if (raw.size() > 16) void'(raw.pop_front());
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  // Monitor: outputs are presented every cycle, checked 1 ns later.
  always @(posedge clk) begin
    logic [5:0] e;
    logic [5:0] act;
    #1;
    act = {c3, r3, f3, c1, r1, f1};
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty t=%0t act=%b", $time, act);
    end else begin
      e = expq.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL sb t=%0t act=%b exp=%b", $time, act, e);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    @(negedge clk);
    btn = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_async_reset();
    logic [5:0] act;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    act = {c3, r3, f3, c1, r1, f1};
    vectors++;
    if (act !== 6'b0) begin
      miscompares++;
      $display("FAIL async_rst act=%b exp=000000", act);
    end
  endtask

  initial begin
    btn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 2);
    hold(1'b0, 8);
    hold(1'b1, 10);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 10);
    hold(1'b1, 8);
    check_async_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 8);
    repeat (120) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 6));
    end
    hold(1'b0, 8);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
